// File: rtl/demux1_3.sv
// One-deep registered 1:3 demultiplexer with valid/ready handshakes,
// a sticky illegal-select flag and saturating per-port delivery counters.
module demux1_3 #(
   parameter int DW = 19
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] in_data,
   input  logic [1:0]    in_sel,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] a_data,
   output logic [DW-1:0] b_data,
   output logic [DW-1:0] c_data,
   output logic          a_valid,
   output logic          b_valid,
   output logic          c_valid,
   input  logic          a_ready,
   input  logic          b_ready,
   input  logic          c_ready,
   input  logic          err_clr,
   output logic          sel_err,
   output logic [7:0]    a_cnt,
   output logic [7:0]    b_cnt,
   output logic [7:0]    c_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state;
   state_t state_nx;

   // Destination is kept one-hot: bit0=a, bit1=b, bit2=c.
   logic [2:0]    dest;
   logic [2:0]    dest_dec;
   logic [DW-1:0] data_q;
   logic [2:0]    rdy_vec;
   logic [2:0]    vld_vec;
   logic          sel_rdy;
   logic          accept;
   logic          deliver;
   logic          illegal;
   logic [7:0]    cnt [3];

   assign rdy_vec = {c_ready, b_ready, a_ready};
   assign sel_rdy = |(dest & rdy_vec);
   assign accept  = in_valid && in_ready;
   assign deliver = (state == FULL) && sel_rdy;
   assign illegal = accept && (in_sel == 2'b10);

   always_comb begin
      dest_dec = 3'b001;
      unique case (in_sel)
         2'b00:   dest_dec = 3'b001;
         2'b01:   dest_dec = 3'b010;
         2'b11:   dest_dec = 3'b100;
         default: dest_dec = 3'b001;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         EMPTY: if (accept) state_nx = FULL;
         FULL:  if (deliver && !accept) state_nx = EMPTY;
      endcase
   end

   // in_ready passes the selected port's ready straight through when FULL.
   always_comb begin
      in_ready = 1'b0;
      vld_vec  = 3'b000;
      if (rst_n) begin
         unique case (state)
            EMPTY: in_ready = 1'b1;
            FULL: begin
               in_ready = sel_rdy;
               vld_vec  = dest;
            end
         endcase
      end
   end

   assign a_valid = vld_vec[0];
   assign b_valid = vld_vec[1];
   assign c_valid = vld_vec[2];
   assign a_data  = data_q;
   assign b_data  = data_q;
   assign c_data  = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dest   <= 3'b000;
         data_q <= '0;
      end else if (accept) begin
         dest   <= dest_dec;
         data_q <= in_data;
      end
   end

   // A same-cycle illegal accept wins over err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err <= 1'b0;
      end else if (illegal) begin
         sel_err <= 1'b1;
      end else if (err_clr) begin
         sel_err <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            cnt[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (deliver && dest[i] && (cnt[i] != 8'hff)) begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   assign a_cnt = cnt[0];
   assign b_cnt = cnt[1];
   assign c_cnt = cnt[2];

endmodule

// File: doc/demux1_3.md
DEMUX1_3 -- requirements
Module: demux1_3

Interface
REQ-001 SHALL have parameter: DW, 19, data width of every data port.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: in_data  input  DW  word to be routed.
REQ-005 SHALL have port: in_sel  input  2  destination code: 00=a, 01=b, 11=c, 10=illegal.
REQ-006 SHALL have port: in_valid  input  1  in_data/in_sel are valid this cycle.
REQ-007 SHALL have port: in_ready  output  1  block accepts the word this cycle.
REQ-008 SHALL have ports: a_data, b_data, c_data  output  DW each  held word, broadcast identically to all three ports.
REQ-009 SHALL have ports: a_valid, b_valid, c_valid  output  1 each  held word is for this port; at most one is high at a time.
REQ-010 SHALL have ports: a_ready, b_ready, c_ready  input  1 each  destination accepts the word.
REQ-011 SHALL have port: err_clr  input  1  synchronous clear of sel_err.
REQ-012 SHALL have port: sel_err  output  1  sticky flag: an illegal in_sel was accepted.
REQ-013 SHALL have ports: a_cnt, b_cnt, c_cnt  output  8 each  saturating count of words delivered per port.

Function
REQ-014 SHALL hold one word in a single registered stage with two states: EMPTY and FULL.
REQ-015 SHALL define the accept event as in_valid && in_ready at a rising clock edge.
REQ-016 SHALL define the delivery event as FULL && x_valid && x_ready for the selected port x, at a rising clock edge.
REQ-017 SHALL drive in_ready = 1 in EMPTY; in FULL, in_ready SHALL equal the ready input of the currently selected port (pass-through).
REQ-018 SHALL transition EMPTY->FULL on accept.
REQ-019 SHALL transition FULL->EMPTY on delivery without accept.
REQ-020 SHALL stay FULL on delivery with accept in the same cycle, replacing the held word and destination with the new word; there SHALL be no bubble cycle.
REQ-021 SHALL stay FULL with word, destination and valid unchanged while the selected port's ready is low.
REQ-022 SHALL decode the destination at accept: 00->a, 01->b, 11->c, 10->a.
REQ-023 SHALL set sel_err on an accept with in_sel=10.
REQ-024 SHALL clear sel_err when err_clr=1, except that a same-cycle illegal accept SHALL take priority and leave sel_err = 1.
REQ-025 SHALL have a latency of exactly 1 cycle: a word accepted at edge N appears with x_valid=1 after edge N.
REQ-026 SHALL assert x_valid only in FULL, only for the decoded destination, and never depending combinationally on x_ready.
REQ-027 SHALL ignore the ready inputs of non-selected ports.
REQ-028 SHALL leave x_data unchanged except on accept.
REQ-029 SHALL increment x_cnt by 1 on each delivery to port x.
REQ-030 SHALL saturate x_cnt at 255; further deliveries SHALL leave it at 255.
REQ-031 SHALL not change x_cnt on accept alone.

Reset
REQ-032 SHALL, while rst_n=0, force state EMPTY, all x_valid=0, all x_data=0, sel_err=0 and all x_cnt=0, regardless of clk.
REQ-033 SHALL, while rst_n=0, drive in_ready=0.
REQ-034 SHALL drop a held word on reset mid-operation; that word SHALL not be delivered and SHALL not be counted.
REQ-035 SHALL drive in_ready=1 on the first cycle after rst_n deasserts.

Verification
REQ-036 SHALL cover basic routing: in_data=19'h12345, in_sel=01, in_valid=1 for one cycle, b_ready=1 -> one cycle later b_valid=1 and b_data=19'h12345; a_valid=0 and c_valid=0; next cycle EMPTY, b_cnt=1.
REQ-037 SHALL cover backpressure: word for c with c_ready=0 for 5 cycles -> c_valid held at 1 and c_data stable; in_ready=0; a_ready=1 has no effect; on c_ready=1 one delivery occurs and c_cnt=1.
REQ-038 SHALL cover streaming: 10 back-to-back words, in_sel alternating 00/11, all ready=1 -> in_ready stays 1; one word delivered per cycle in order; a_cnt=5, c_cnt=5.
REQ-039 SHALL cover the illegal code: accept with in_sel=10 -> a_valid=1 and sel_err=1; err_clr pulse -> sel_err=0; err_clr together with another in_sel=10 accept -> sel_err stays 1.
REQ-040 SHALL cover saturation: 260 deliveries to port a -> a_cnt=255.
REQ-041 SHALL cover mid-operation reset: rst_n pulled low while FULL with b_ready=0 -> immediately b_valid=0, b_cnt=0 and in_ready=0; after release in_ready=1 and no delivery of the old word.
